// File: rtl/nott_seq_pkg.sv
// Shared types and default spacing for sequencers driving clocked RSFQ cells.
package nott_seq_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DC,
    ST_WAIT_Q,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_N_REQ    = 4;
  localparam int unsigned DEF_INIT_CYC = 4;
  localparam int unsigned DEF_T_DC     = 2;
  localparam int unsigned DEF_T_CC     = 3;
  localparam int unsigned DEF_T_CD     = 1;
  localparam int unsigned DEF_Q_WAIT   = 2;

  localparam int unsigned CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t dec_sat(input cnt_t v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

endpackage

// File: rtl/nott_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr.
module nott_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] win,
  output logic [IW-1:0]    win_idx,
  output logic             any
);

  logic [IW-1:0] k;

  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    k       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = IW'((32'(ptr) + i) % N_REQ);
      if (!any && req[k]) begin
        any     = 1'b1;
        win[k]  = 1'b1;
        win_idx = k;
      end
    end
  end

endmodule

// File: rtl/nott_sequencer.sv
// Time-shares one clocked RSFQ inverter among N requesters using
// toggle-encoded data/clock pulses with programmable spacing.
module nott_sequencer
  import nott_seq_pkg::*;
#(
  parameter int unsigned N_REQ    = DEF_N_REQ,
  parameter int unsigned INIT_CYC = DEF_INIT_CYC,
  parameter int unsigned T_DC     = DEF_T_DC,
  parameter int unsigned T_CC     = DEF_T_CC,
  parameter int unsigned T_CD     = DEF_T_CD,
  parameter int unsigned Q_WAIT   = DEF_Q_WAIT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_data,
  output logic [N_REQ-1:0]         gnt,
  output logic                     cell_a,
  output logic                     cell_clk,
  input  logic                     cell_q,
  output logic                     rsp_valid,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic                     rsp_data,
  output logic                     rsp_err,
  output logic                     spurious
);

  localparam int unsigned IW = $clog2(N_REQ);

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] cur_id;
  logic          cur_data;
  logic          q_prev;
  logic          q_armed;
  logic          q_seen;
  logic          q_tog;
  cnt_t          init_cnt;
  cnt_t          dc_cnt;
  cnt_t          cc_cnt;
  cnt_t          cd_cnt;
  cnt_t          qw_cnt;

  logic [N_REQ-1:0] arb_win;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;

  nott_rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .win     (arb_win),
    .win_idx (arb_idx),
    .any     (arb_any)
  );

  // q_prev is only meaningful after the first clock out of reset.
  assign q_tog = q_armed & (cell_q ^ q_prev);

  // Spacing counters hold (min cycles - 1): a toggle is allowed on the edge
  // where the counter already reads zero, so the gap is at least the minimum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      rr_ptr    <= '0;
      cur_id    <= '0;
      cur_data  <= 1'b0;
      q_prev    <= 1'b0;
      q_armed   <= 1'b0;
      q_seen    <= 1'b0;
      init_cnt  <= '0;
      dc_cnt    <= '0;
      cc_cnt    <= '0;
      cd_cnt    <= '0;
      qw_cnt    <= '0;
      gnt       <= '0;
      cell_a    <= 1'b0;
      cell_clk  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= 1'b0;
      rsp_err   <= 1'b0;
      spurious  <= 1'b0;
    end else begin
      q_prev    <= cell_q;
      q_armed   <= 1'b1;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      dc_cnt    <= dec_sat(dc_cnt);
      cc_cnt    <= dec_sat(cc_cnt);
      cd_cnt    <= dec_sat(cd_cnt);
      if (q_tog && state != ST_WAIT_Q) spurious <= 1'b1;

      case (state)
        ST_INIT: begin
          if (32'(init_cnt) + 32'd1 >= INIT_CYC) state <= ST_IDLE;
          else init_cnt <= init_cnt + 1'b1;
        end
        ST_IDLE: begin
          if (arb_any && cd_cnt == '0) begin
            cur_id   <= arb_idx;
            cur_data <= req_data[arb_idx];
            gnt      <= arb_win;
            cell_a   <= cell_a ^ req_data[arb_idx];
            dc_cnt   <= cnt_t'(T_DC - 1);
            rr_ptr   <= (32'(arb_idx) + 32'd1 >= N_REQ) ? '0 : arb_idx + 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT_DC;
        ST_WAIT_DC: begin
          if (dc_cnt == '0 && cc_cnt == '0) begin
            cell_clk <= ~cell_clk;
            cc_cnt   <= cnt_t'(T_CC - 1);
            cd_cnt   <= cnt_t'(T_CD - 1);
            qw_cnt   <= cnt_t'(Q_WAIT);
            q_seen   <= 1'b0;
            state    <= ST_WAIT_Q;
          end
        end
        ST_WAIT_Q: begin
          if (q_tog) begin
            q_seen <= 1'b1;
            if (q_seen) spurious <= 1'b1;
          end
          qw_cnt <= qw_cnt - 1'b1;
          if (qw_cnt == cnt_t'(1)) state <= ST_DONE;
        end
        ST_DONE: begin
          rsp_valid <= 1'b1;
          rsp_id    <= cur_id;
          rsp_data  <= q_seen;
          rsp_err   <= (q_seen == cur_data);
          state     <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_nott_sequencer.sv
// Scoreboard bench for nott_sequencer with a behavioural inverter-cell model.
module tb_nott_sequencer;

  localparam int unsigned N        = 4;
  localparam int unsigned IW       = 2;
  localparam int unsigned INIT_CYC = 4;
  localparam int unsigned T_DC     = 2;
  localparam int unsigned T_CC     = 3;
  localparam int unsigned T_CD     = 1;
  localparam int unsigned Q_WAIT   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  req_data = '0;
  logic [N-1:0]  gnt;
  logic          cell_a;
  logic          cell_clk;
  logic          cell_q = 1'b0;
  logic          rsp_valid;
  logic [IW-1:0] rsp_id;
  logic          rsp_data;
  logic          rsp_err;
  logic          spurious;

  nott_sequencer #(
    .N_REQ    (N),
    .INIT_CYC (INIT_CYC),
    .T_DC     (T_DC),
    .T_CC     (T_CC),
    .T_CD     (T_CD),
    .Q_WAIT   (Q_WAIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .cell_a    (cell_a),
    .cell_clk  (cell_clk),
    .cell_q    (cell_q),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .spurious  (spurious)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [IW-1:0] id;
    logic          data;
    logic          q;
  } exp_t;
  exp_t exp_q[$];

  logic [N-1:0] pend = '0;
  logic [N-1:0] pend_data = '0;
  int unsigned  model_rr = 0;
  logic         fault_noq = 1'b0;
  logic         inject_q = 1'b0;

  // Clocked inverter: output pulse on a clock pulse unless a data pulse arrived since the last clock.
  initial begin
    logic a_last, c_last, a_pend;
    a_last = 1'b0; c_last = 1'b0; a_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        a_pend = 1'b0;
      end else begin
        if (cell_a != a_last) a_pend = 1'b1;
        if (cell_clk != c_last) begin
          if (!a_pend && !fault_noq) cell_q = ~cell_q;
          a_pend = 1'b0;
        end
        if (inject_q) begin
          cell_q   = ~cell_q;
          inject_q = 1'b0;
        end
      end
      a_last = cell_a;
      c_last = cell_clk;
    end
  end

  // Monitor: pulse spacing checks and scoreboard pops on rsp_valid.
  initial begin
    logic pa, pc;
    int   last_clk, last_gnt;
    exp_t e;
    pa = 1'b0; pc = 1'b0; last_clk = -1000; last_gnt = -1000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pa = cell_a; pc = cell_clk; last_clk = -1000;
        continue;
      end
      if (gnt != '0) last_gnt = cyc;
      if (cell_a != pa) begin
        check("data_pulse_with_gnt", 32'(gnt != '0), 1);
        if (last_clk >= 0) check("clk_to_data_spacing", 32'((cyc - last_clk) >= int'(T_CD)), 1);
      end
      if (cell_clk != pc) begin
        check("gnt_to_clk_latency", cyc - last_gnt, T_DC);
        if (last_clk >= 0) check("clk_to_clk_spacing", 32'((cyc - last_clk) >= int'(T_CC)), 1);
        last_clk = cyc;
      end
      if (rsp_valid) begin
        check("rsp_latency", cyc - last_clk, Q_WAIT + 1);
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_data", rsp_data, e.q);
          check("rsp_err", rsp_err, e.q != !e.data);
        end
      end
      pa = cell_a;
      pc = cell_clk;
    end
  end

  task automatic push_expect(input int unsigned id);
    exp_t e;
    e.id   = IW'(id);
    e.data = pend_data[id];
    e.q    = fault_noq ? 1'b0 : !pend_data[id];
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 100) begin
      @(negedge clk);
      b++;
    end
    check("all_responses_seen", exp_q.size(), 0);
  endtask

  task automatic run_batch(input logic [N-1:0] mask, input logic [N-1:0] data);
    int          budget;
    int unsigned exp_id;
    logic        found;
    @(negedge clk);
    pend = mask; pend_data = data;
    req_data = data; req = mask;
    budget = 0;
    while (pend != '0 && budget < 200) begin
      @(negedge clk);
      budget++;
      if (gnt != '0) begin
        found = 1'b0; exp_id = 0;
        for (int k = 0; k < int'(N); k++) begin
          if (!found && pend[(model_rr + k) % N]) begin
            found = 1'b1;
            exp_id = (model_rr + k) % N;
          end
        end
        check("grant_order", 32'(gnt), 32'(1) << exp_id);
        push_expect(exp_id);
        pend[exp_id] = 1'b0;
        req[exp_id]  = 1'b0;
        model_rr = (exp_id + 1) % N;
      end
    end
    check("all_granted", 32'(pend), 0);
    req = '0;
    drain();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 0);
    check({tag, "_cell_a"}, 32'(cell_a), 0);
    check({tag, "_cell_clk"}, 32'(cell_clk), 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 0);
    check({tag, "_spurious"}, 32'(spurious), 0);
  endtask

  initial begin
    int b;
    int cnt;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    #1 rst_n = 1'b1;

    run_batch(4'b0001, 4'b0000);
    run_batch(4'b0100, 4'b0100);
    run_batch(4'b1111, 4'b1010);
    run_batch(4'b0001, 4'b0001);
    for (int i = 0; i < 15; i++) begin
      run_batch(N'($urandom_range(1, 15)), N'($urandom));
    end
    check("no_spurious_normal", 32'(spurious), 0);

    fault_noq = 1'b1;
    run_batch(4'b0001, 4'b0000);
    run_batch(4'b1000, 4'b1000);
    fault_noq = 1'b0;

    repeat (3) @(negedge clk);
    inject_q = 1'b1;
    repeat (3) @(negedge clk);
    check("spurious_set_idle", 32'(spurious), 1);
    run_batch(4'b0010, 4'b0000);
    check("spurious_sticky", 32'(spurious), 1);

    // Reset in the middle of the response window.
    @(negedge clk);
    pend = 4'b0010; pend_data = 4'b0000;
    req_data = 4'b0000; req = 4'b0010;
    b = 0;
    while (gnt == '0 && b < 50) begin @(negedge clk); b++; end
    check("midop_grant_seen", 32'(gnt), 32'(4'b0010));
    b = 0;
    begin
      logic c0;
      c0 = cell_clk;
      while (cell_clk == c0 && b < 50) begin @(negedge clk); b++; end
      check("midop_clk_seen", 32'(cell_clk != c0), 1);
    end
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midop_reset");
    exp_q.delete();
    model_rr = 0;
    repeat (3) @(negedge clk);
    check_outputs_zero("midop_held");
    #1 rst_n = 1'b1;
    cnt = 0;
    while (cnt < 50) begin
      @(posedge clk);
      cnt++;
      #1;
      if (gnt != '0) break;
    end
    check("first_gnt_after_reset", 32'(cnt >= int'(INIT_CYC + 1)), 1);
    check("first_gnt_id", 32'(gnt), 32'(4'b0010));
    push_expect(1);
    req = '0; pend = '0;
    model_rr = 2;
    drain();
    check("no_spurious_after_reset", 32'(spurious), 0);

    run_batch(4'b1111, N'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
